// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, ALUOp, PCSrc and RegDst.
// The ALUOp constants are also consumed by the ALU.
package ctrl_pkg;

   typedef enum logic [2:0] {
      S_IF     = 3'b000,
      S_ID     = 3'b001,
      S_EXE_LS = 3'b010,
      S_MEM    = 3'b011,
      S_WB_LD  = 3'b100,
      S_EXE_BR = 3'b101,
      S_EXE_AL = 3'b110,
      S_WB_AL  = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD   = 6'b000000;
   localparam logic [5:0] OP_SUB   = 6'b000001;
   localparam logic [5:0] OP_ADDIU = 6'b000010;
   localparam logic [5:0] OP_AND   = 6'b010000;
   localparam logic [5:0] OP_ANDI  = 6'b010001;
   localparam logic [5:0] OP_OR    = 6'b010010;
   localparam logic [5:0] OP_ORI   = 6'b010011;
   localparam logic [5:0] OP_XORI  = 6'b010100;
   localparam logic [5:0] OP_SLL   = 6'b011000;
   localparam logic [5:0] OP_SLT   = 6'b100110;
   localparam logic [5:0] OP_SLTI  = 6'b100111;
   localparam logic [5:0] OP_SW    = 6'b110000;
   localparam logic [5:0] OP_LW    = 6'b110001;
   localparam logic [5:0] OP_BEQ   = 6'b110100;
   localparam logic [5:0] OP_BNE   = 6'b110101;
   localparam logic [5:0] OP_BLTZ  = 6'b110110;
   localparam logic [5:0] OP_J     = 6'b111000;
   localparam logic [5:0] OP_JR    = 6'b111001;
   localparam logic [5:0] OP_JAL   = 6'b111010;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_SLTU  = 3'b010;
   localparam logic [2:0] ALU_SLT   = 3'b011;
   localparam logic [2:0] ALU_SHIFT = 3'b100;
   localparam logic [2:0] ALU_OR    = 3'b101;
   localparam logic [2:0] ALU_AND   = 3'b110;
   localparam logic [2:0] ALU_XOR   = 3'b111;

   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_RS     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   localparam logic [1:0] RD_RA = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RD = 2'b10;

   function automatic logic is_alu_inst(input logic [5:0] op);
      return op inside {OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_OR,
                        OP_ORI, OP_XORI, OP_SLT, OP_SLTI, OP_SLL};
   endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode decode of the datapath steering fields (ALUOp, operand sources,
// extension mode, destination register select). The FSM gates these per state.
module alu_op_decode
   import ctrl_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic [OPW-1:0] opcode,
   output logic [2:0]     alu_op,
   output logic           alu_src_a,
   output logic           alu_src_b,
   output logic           ext_sel,
   output logic [1:0]     reg_dst
);

   always_comb begin
      alu_op    = ALU_ADD;
      alu_src_a = 1'b0;
      alu_src_b = 1'b0;
      ext_sel   = 1'b1;
      reg_dst   = RD_RA;
      case (opcode)
         OP_ADD:   reg_dst = RD_RD;
         OP_SUB:   begin alu_op = ALU_SUB;   reg_dst = RD_RD; end
         OP_ADDIU: begin alu_src_b = 1'b1;   reg_dst = RD_RT; end
         OP_AND:   begin alu_op = ALU_AND;   reg_dst = RD_RD; end
         OP_ANDI:  begin alu_op = ALU_AND;   alu_src_b = 1'b1; ext_sel = 1'b0; reg_dst = RD_RT; end
         OP_OR:    begin alu_op = ALU_OR;    reg_dst = RD_RD; end
         OP_ORI:   begin alu_op = ALU_OR;    alu_src_b = 1'b1; ext_sel = 1'b0; reg_dst = RD_RT; end
         OP_XORI:  begin alu_op = ALU_XOR;   alu_src_b = 1'b1; ext_sel = 1'b0; reg_dst = RD_RT; end
         OP_SLT:   begin alu_op = ALU_SLT;   reg_dst = RD_RD; end
         OP_SLTI:  begin alu_op = ALU_SLT;   alu_src_b = 1'b1; reg_dst = RD_RT; end
         OP_SLL:   begin alu_op = ALU_SHIFT; alu_src_a = 1'b1; reg_dst = RD_RD; end
         OP_LW, OP_SW:            begin alu_src_b = 1'b1; reg_dst = RD_RT; end
         OP_BEQ, OP_BNE, OP_BLTZ: begin alu_op = ALU_SUB; reg_dst = RD_RT; end
         default: ;
      endcase
   end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM driving all datapath enables and selects.
// Optional jr/jal support is compiled in with CTRL_JUMP_EXT_EN.
//
// state     | meaning
// S_IF      | fetch: load IR from instruction memory
// S_ID      | decode; j/NOP/jr/jal finish here; halt parks here with the halt flag set
// S_EXE_AL  | ALU operation
// S_WB_AL   | ALU result write-back, PC+4
// S_EXE_BR  | branch compare, PC commit
// S_EXE_LS  | load/store address computation
// S_MEM     | data-memory access
// S_WB_LD   | load data write-back
module multi_cycle_ctrl
   import ctrl_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic           CLK,
   input  logic           Reset,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   input  logic           sign,
   output logic [2:0]     state,
   output logic           PCWre,
   output logic           IRWre,
   output logic           InsMemRW,
   output logic           RegWre,
   output logic           mRD,
   output logic           mWR,
   output logic           ALUSrcA,
   output logic           ALUSrcB,
   output logic           ExtSel,
   output logic           DBDataSrc,
   output logic           WrRegDSrc,
   output logic [1:0]     RegDst,
   output logic [1:0]     PCSrc,
   output logic [2:0]     ALUOp
);

   state_t     state_q, state_d;
   logic       halted, halted_d;
   logic [2:0] dec_alu_op;
   logic       dec_src_a, dec_src_b, dec_ext_sel;
   logic [1:0] dec_reg_dst;
   logic       br_taken;

   alu_op_decode #(.OPW(OPW)) u_dec (
      .opcode    (opcode),
      .alu_op    (dec_alu_op),
      .alu_src_a (dec_src_a),
      .alu_src_b (dec_src_b),
      .ext_sel   (dec_ext_sel),
      .reg_dst   (dec_reg_dst)
   );

   assign br_taken = (opcode == OP_BEQ  &&  zero) ||
                     (opcode == OP_BNE  && !zero) ||
                     (opcode == OP_BLTZ &&  sign);

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IF;
         halted  <= 1'b0;
      end else begin
         state_q <= state_d;
         halted  <= halted_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      halted_d  = halted;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      InsMemRW  = 1'b0;
      RegWre    = 1'b0;
      mRD       = 1'b0;
      mWR       = 1'b0;
      DBDataSrc = 1'b0;
      WrRegDSrc = 1'b0;
      PCSrc     = PC_NEXT;
      ALUOp     = ALU_ADD;
      ALUSrcA   = 1'b0;
      ALUSrcB   = 1'b0;
      ExtSel    = 1'b0;
      RegDst    = RD_RA;
      // fetch must not depend on the stale opcode, and a halted core drives nothing
      if (state_q != S_IF && !halted) begin
         ALUOp   = dec_alu_op;
         ALUSrcA = dec_src_a;
         ALUSrcB = dec_src_b;
         ExtSel  = dec_ext_sel;
         RegDst  = dec_reg_dst;
      end
      case (state_q)
         S_IF: begin
            IRWre    = 1'b1;
            InsMemRW = 1'b1;
            state_d  = S_ID;
         end
         S_ID: begin
            if (!halted) begin
               if (is_alu_inst(opcode)) begin
                  state_d = S_EXE_AL;
               end else begin
                  case (opcode)
                     OP_BEQ, OP_BNE, OP_BLTZ: state_d = S_EXE_BR;
                     OP_LW, OP_SW:            state_d = S_EXE_LS;
                     OP_J: begin
                        PCSrc   = PC_JUMP;
                        PCWre   = 1'b1;
                        state_d = S_IF;
                     end
                     OP_HALT: halted_d = 1'b1;
`ifdef CTRL_JUMP_EXT_EN
                     OP_JR: begin
                        PCSrc   = PC_RS;
                        PCWre   = 1'b1;
                        state_d = S_IF;
                     end
                     OP_JAL: begin
                        RegWre    = 1'b1;
                        RegDst    = RD_RA;
                        WrRegDSrc = 1'b0;
                        PCSrc     = PC_JUMP;
                        PCWre     = 1'b1;
                        state_d   = S_IF;
                     end
`endif
                     default: begin
                        PCWre   = 1'b1;
                        state_d = S_IF;
                     end
                  endcase
               end
            end
         end
         S_EXE_AL: state_d = S_WB_AL;
         S_WB_AL: begin
            RegWre    = 1'b1;
            PCWre     = 1'b1;
            WrRegDSrc = 1'b1;
            state_d   = S_IF;
         end
         S_EXE_BR: begin
            ALUOp   = ALU_SUB;
            PCSrc   = br_taken ? PC_BRANCH : PC_NEXT;
            PCWre   = 1'b1;
            state_d = S_IF;
         end
         S_EXE_LS: begin
            ALUOp   = ALU_ADD;
            ALUSrcB = 1'b1;
            ExtSel  = 1'b1;
            state_d = S_MEM;
         end
         S_MEM: begin
            if (opcode == OP_SW) begin
               mWR     = 1'b1;
               PCWre   = 1'b1;
               state_d = S_IF;
            end else begin
               mRD     = 1'b1;
               state_d = S_WB_LD;
            end
         end
         S_WB_LD: begin
            mRD       = 1'b1;
            DBDataSrc = 1'b1;
            RegWre    = 1'b1;
            WrRegDSrc = 1'b1;
            RegDst    = RD_RT;
            PCWre     = 1'b1;
            state_d   = S_IF;
         end
         default: state_d = S_IF;
      endcase
   end

   assign state = state_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed cases plus a random instruction
// stream checked cycle by cycle against a per-instruction trace model.
module tb_multi_cycle_ctrl;
   import ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] opcode;
   logic       zero, sign;
   logic [2:0] state;
   logic       pc_wre, ir_wre, ins_mem_rw, reg_wre, m_rd, m_wr;
   logic       alu_src_a, alu_src_b, ext_sel, db_data_src, wr_reg_d_src;
   logic [1:0] reg_dst, pc_src;
   logic [2:0] alu_op;

   int n_checks = 0;
   int n_errors = 0;

   localparam int K_ALU = 0, K_BR = 1, K_LW = 2, K_SW = 3, K_J = 4, K_JR = 5, K_JAL = 6, K_NOP = 7;

   multi_cycle_ctrl #(.OPW(6)) dut (
      .CLK(clk), .Reset(rst), .opcode(opcode), .zero(zero), .sign(sign),
      .state(state), .PCWre(pc_wre), .IRWre(ir_wre), .InsMemRW(ins_mem_rw),
      .RegWre(reg_wre), .mRD(m_rd), .mWR(m_wr), .ALUSrcA(alu_src_a),
      .ALUSrcB(alu_src_b), .ExtSel(ext_sel), .DBDataSrc(db_data_src),
      .WrRegDSrc(wr_reg_d_src), .RegDst(reg_dst), .PCSrc(pc_src), .ALUOp(alu_op)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int classify(input logic [5:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_OR, OP_ORI,
         OP_XORI, OP_SLT, OP_SLTI, OP_SLL: return K_ALU;
         OP_BEQ, OP_BNE, OP_BLTZ: return K_BR;
         OP_LW: return K_LW;
         OP_SW: return K_SW;
         OP_J:  return K_J;
`ifdef CTRL_JUMP_EXT_EN
         OP_JR:  return K_JR;
         OP_JAL: return K_JAL;
`endif
         default: return K_NOP;
      endcase
   endfunction

   function automatic int exp_alu_op(input logic [5:0] op);
      case (op)
         OP_SUB:          return 1;
         OP_SLT, OP_SLTI: return 3;
         OP_SLL:          return 4;
         OP_OR, OP_ORI:   return 5;
         OP_AND, OP_ANDI: return 6;
         OP_XORI:         return 7;
         default:         return 0;
      endcase
   endfunction

   function automatic logic is_rtype(input logic [5:0] op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL};
   endfunction

   function automatic int n_cycles(input int k);
      case (k)
         K_ALU:   return 4;
         K_BR:    return 3;
         K_LW:    return 5;
         K_SW:    return 4;
         default: return 2;
      endcase
   endfunction

   function automatic int state_at(input int k, input int i);
      if (i == 0) return 0;
      if (i == 1) return 1;
      case (k)
         K_ALU:   return (i == 2) ? 6 : 7;
         K_BR:    return 5;
         K_LW:    return (i == 2) ? 2 : ((i == 3) ? 3 : 4);
         K_SW:    return (i == 2) ? 2 : 3;
         default: return 0;
      endcase
   endfunction

   // Enter positioned just after a rising edge with the DUT in sIF; leave the same way.
   task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
      int   k, n, ep;
      logic last, taken, writes;
      k      = classify(op);
      n      = n_cycles(k);
      taken  = (op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BLTZ && s);
      writes = (k == K_ALU) || (k == K_LW) || (k == K_JAL);
      zero   = z;
      sign   = s;
      for (int i = 0; i < n; i++) begin
         opcode = (i == 0) ? 6'($urandom) : op;
         @(negedge clk);
         last = (i == n - 1);
         chk("state", 32'(state), 32'(state_at(k, i)));
         chk("pcwre", 32'(pc_wre), 32'(last));
         chk("irwre", 32'(ir_wre), 32'(i == 0));
         chk("insmem", 32'(ins_mem_rw), 32'(i == 0));
         chk("regwre", 32'(reg_wre), 32'(last && writes));
         chk("mrd", 32'(m_rd), 32'(k == K_LW && i >= 3));
         chk("mwr", 32'(m_wr), 32'(k == K_SW && i == 3));
         if (!last)                      ep = 0;
         else if (k == K_J || k == K_JAL) ep = 3;
         else if (k == K_JR)              ep = 2;
         else if (k == K_BR && taken)     ep = 1;
         else                             ep = 0;
         chk("pcsrc", 32'(pc_src), 32'(ep));
         if (i == 0) begin
            chk("if_aluop", 32'(alu_op), 0);
            chk("if_regdst", 32'(reg_dst), 0);
            chk("if_extsel", 32'(ext_sel), 0);
            chk("if_srcb", 32'(alu_src_b), 0);
         end
         if (i == 2 && k == K_ALU) begin
            chk("al_aluop", 32'(alu_op), 32'(exp_alu_op(op)));
            chk("al_srca", 32'(alu_src_a), 32'(op == OP_SLL));
            chk("al_srcb", 32'(alu_src_b), 32'(!is_rtype(op)));
            chk("al_extsel", 32'(ext_sel), 32'(!(op inside {OP_ANDI, OP_ORI, OP_XORI})));
         end
         if (i == 2 && k == K_BR) chk("br_aluop", 32'(alu_op), 1);
         if (i == 2 && (k == K_LW || k == K_SW)) begin
            chk("ls_aluop", 32'(alu_op), 0);
            chk("ls_srcb", 32'(alu_src_b), 1);
            chk("ls_extsel", 32'(ext_sel), 1);
         end
         if (last && writes) begin
            chk("wb_regdst", 32'(reg_dst),
                32'((k == K_JAL) ? 0 : ((k == K_ALU && is_rtype(op)) ? 2 : 1)));
            chk("wb_dbsrc", 32'(db_data_src), 32'(k == K_LW));
            chk("wb_wrsrc", 32'(wr_reg_d_src), 32'(k != K_JAL));
         end
         @(posedge clk);
         #1;
      end
   endtask

   logic [5:0] known_ops [19];

   initial begin
      known_ops = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_OR, OP_ORI, OP_XORI,
                    OP_SLL, OP_SLT, OP_SLTI, OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ,
                    OP_J, OP_JR, OP_JAL};
      rst = 1'b1; opcode = 6'h2a; zero = 1'b0; sign = 1'b0;
      #2;
      chk("rst_state", 32'(state), 0);
      chk("rst_irwre", 32'(ir_wre), 1);
      chk("rst_insmem", 32'(ins_mem_rw), 1);
      chk("rst_pcwre", 32'(pc_wre), 0);
      chk("rst_regwre", 32'(reg_wre), 0);
      chk("rst_pcsrc", 32'(pc_src), 0);
      chk("rst_aluop", 32'(alu_op), 0);
      chk("rst_regdst", 32'(reg_dst), 0);
      @(posedge clk); #1;
      chk("rst_hold", 32'(state), 0);
      rst = 1'b0;

      run_instr(OP_ADD, 1'b0, 1'b0);
      run_instr(OP_BEQ, 1'b1, 1'b0);
      run_instr(OP_BNE, 1'b1, 1'b0);
      run_instr(OP_BNE, 1'b0, 1'b1);
      run_instr(OP_BLTZ, 1'b0, 1'b1);
      run_instr(OP_BLTZ, 1'b1, 1'b0);
      run_instr(OP_LW, 1'b0, 1'b0);
      run_instr(OP_SW, 1'b0, 1'b0);
      run_instr(OP_JAL, 1'b0, 1'b0);
      run_instr(OP_JR, 1'b0, 1'b0);
      run_instr(OP_J, 1'b0, 1'b0);
      run_instr(OP_SLL, 1'b0, 1'b0);
      run_instr(OP_XORI, 1'b0, 1'b0);

      // reset while in sWB_LD abandons the load write-back
      opcode = 6'h15;
      @(posedge clk); #1;
      opcode = OP_LW;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      chk("ld_state", 32'(state), 4);
      chk("ld_regwre", 32'(reg_wre), 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_state", 32'(state), 0);
      chk("mid_rst_regwre", 32'(reg_wre), 0);
      chk("mid_rst_mrd", 32'(m_rd), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int t = 0; t < 300; t++) begin
         logic [5:0] op;
         if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 62));
         else                           op = known_ops[$urandom_range(0, 18)];
         run_instr(op, 1'($urandom), 1'($urandom));
      end

      // halt parks in sID until reset
      opcode = 6'h00;
      @(posedge clk); #1;
      opcode = OP_HALT;
      @(posedge clk); #1;
      for (int c = 0; c < 20; c++) begin
         opcode = 6'($urandom);
         @(negedge clk);
         chk("halt_state", 32'(state), 1);
         chk("halt_pcwre", 32'(pc_wre), 0);
         chk("halt_regwre", 32'(reg_wre), 0);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      #1;
      chk("halt_rst_state", 32'(state), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_instr(OP_ADD, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
